mux_arb_rtl: RTL and testbench
==============================

# mux_arb_rtl

Parametrised N-channel registered multiplexer with valid/ready handshaking and a selectable arbitration mode. It generalises the combinational 8:1 select mux: channel count and width are parameters, selection is static (external `sel`) or round-robin, and the output is held in a one-entry pipeline register with full back-pressure. It sits at datapath merge points in the TinyRV1 processor and test harness where several producers share one consumer, such as memory request merging and writeback source selection.

## Interface

- `p_nbits`, 32, message width per channel.
- `p_nchannels`, 8, number of input channels; legal range 2..16.
- `p_sel_bits`, $clog2(p_nchannels), width of `sel` and `out_sel`; derived, never overridden.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `mode`  in  1  0 = static select via `sel`; 1 = round-robin.
- `sel`  in  p_sel_bits  channel chosen in static mode.
- `in_msg`  in  p_nchannels*p_nbits  flattened messages; channel i occupies bits [i*p_nbits +: p_nbits].
- `in_val`  in  p_nchannels  per-channel valid.
- `in_rdy`  out  p_nchannels  per-channel ready; one-hot or zero.
- `out_msg`  out  p_nbits  registered message.
- `out_val`  out  1  registered valid.
- `out_sel`  out  p_sel_bits  index of the channel that produced `out_msg`.
- `out_rdy`  in  1  consumer ready.

## Operation

- **Output register.** One entry, holding `out_msg`, `out_val` and `out_sel`.
  - `can_load` = !out_val || out_rdy.
  - An output transfer occurs on a cycle with out_val && out_rdy.
- **Grant, static mode (mode=0).**
  - Candidate is `sel`.
  - grant_valid = (sel < p_nchannels) && in_val[sel].
  - An out-of-range `sel` never grants.
- **Grant, round-robin mode (mode=1).**
  - Search starts at pointer `ptr` and proceeds upward, wrapping modulo p_nchannels.
  - The first channel with in_val set is granted.
- **Input handshake.**
  - in_rdy[g] = grant_valid && can_load, where g is the granted index. All other in_rdy bits are 0.
  - An input transfer occurs on channel g when in_val[g] && in_rdy[g].
  - in_rdy is combinational from in_val, mode, sel, ptr, out_val and out_rdy.
  - in_rdy never depends on the input message.
- **Register update on the rising edge.**
  - Input transfer: out_msg ← channel g message, out_sel ← g, out_val ← 1.
  - Otherwise, if an output transfer occurred: out_val ← 0. out_msg and out_sel hold their stale values.
  - Otherwise: hold.
- **Pointer.**
  - Updates only on an input transfer in round-robin mode: ptr ← (g+1) mod p_nchannels. It must wrap correctly for non-power-of-two p_nchannels.
  - Static-mode transfers leave ptr unchanged.
- **Mode and `sel` changes.**
  - Both may change on any cycle and take effect on the same cycle's grant.
  - Contents of the output register are never disturbed by a mode or `sel` change.
- **Reset** (rst_n=0 at a rising edge): out_val=0, out_msg=0, out_sel=0, ptr=0.
  - Reset dominates any simultaneous transfer, and an in-flight message is dropped.
  - While rst_n=0, in_rdy is forced to all-zero.

## Timing

- Latency is 1 cycle: a message accepted at edge k appears on out_msg/out_val after edge k.
- Throughput is 1 message per cycle while out_rdy=1. Back-to-back transfers are required with no bubble.
- Simultaneous output and input transfer in the same cycle: the new message replaces the old one and out_val stays 1.
- Output full and out_rdy=0: all in_rdy=0, and out_msg, out_val and out_sel are stable until out_rdy rises.
- Producers must hold in_msg/in_val until their transfer; the block does not latch unaccepted inputs.
- The grant may change combinationally between cycles when no transfer has occurred, for example when in_val changes. This is legal.

## Test plan

- **Reset.** Hold rst_n=0 for 2 cycles with all in_val=1.
  - Required: out_val=0, out_msg=0, out_sel=0 and in_rdy=0 throughout.
  - Then release with mode=1: the first accepted message comes from channel 0.
- **Static streaming.** p_nchannels=8, p_nbits=32, mode=0, sel=5, in_val=8'hFF, channel i message = 32'hA0+i, out_rdy=1.
  - Required: in_rdy=8'h20 every cycle, out_msg=32'hA5 and out_sel=5 from cycle 1 on, out_val continuously 1.
- **Round-robin fairness and wrap.** mode=1, in_val=8'b1000_0101, out_rdy=1.
  - Required: grant order 0, 2, 7, 0, 2, 7, …, with out_sel following one cycle later.
  - Repeat with p_nchannels=5 and in_val=5'b10001: order 0, 4, 0, 4, …
- **Back-pressure.** Deassert out_rdy for 3 cycles mid-stream.
  - Required: out_val=1 with out_msg/out_sel frozen, all in_rdy=0, ptr frozen.
  - On out_rdy=1, transfer resumes the same cycle with no lost or duplicated message.
- **Out-of-range select.** p_nchannels=5, mode=0, sel=6, all in_val=1.
  - Required: in_rdy=0 and out_val falls to 0 after the pending message drains.
  - Switching mode to 1 that cycle grants from ptr on the same cycle.
- **Reset mid-operation.** out_val=1 holding 32'hA3 with out_rdy=0; assert rst_n=0 for one edge.
  - Required: out_val=0, out_msg=0, ptr=0 after that edge, and the held message is never delivered.

Source files
------------

// File: rtl/mux_arb_rtl.sv
// N-channel registered mux, static-select or round-robin arbitration, valid/ready on both sides.
// Latency: 1 cycle from input acceptance to out_val/out_msg; 1 message/cycle sustained.
// Backpressure: in_rdy is zero while the output register is full and out_rdy is low.
module mux_arb_rtl #(
    parameter int p_nbits     = 32,
    parameter int p_nchannels = 8,
    parameter int p_sel_bits  = $clog2(p_nchannels)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           mode,
    input  logic [p_sel_bits-1:0]          sel,
    input  logic [p_nchannels*p_nbits-1:0] in_msg,
    input  logic [p_nchannels-1:0]         in_val,
    output logic [p_nchannels-1:0]         in_rdy,
    output logic [p_nbits-1:0]             out_msg,
    output logic                           out_val,
    output logic [p_sel_bits-1:0]          out_sel,
    input  logic                           out_rdy
);

    logic [p_sel_bits-1:0] ptr;
    logic [p_sel_bits-1:0] grant_idx;
    logic [p_sel_bits-1:0] cand;
    logic [p_sel_bits:0]   sum;
    logic                  grant_vld;
    logic                  can_load;
    logic                  xfer_in;

    assign can_load = !out_val || out_rdy;
    assign xfer_in  = rst_n && grant_vld && can_load;

    // Round-robin scans offsets from the top down so the lowest offset from ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        sum       = '0;
        cand      = '0;
        if (!mode) begin
            if ({1'b0, sel} < (p_sel_bits+1)'(p_nchannels)) begin
                grant_idx = sel;
                grant_vld = in_val[sel];
            end
        end else begin
            for (int k = p_nchannels - 1; k >= 0; k--) begin
                sum = {1'b0, ptr} + (p_sel_bits+1)'(k);
                if (sum >= (p_sel_bits+1)'(p_nchannels))
                    sum = sum - (p_sel_bits+1)'(p_nchannels);
                cand = sum[p_sel_bits-1:0];
                if (in_val[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        in_rdy = '0;
        if (xfer_in)
            in_rdy[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_val <= 1'b0;
            out_msg <= '0;
            out_sel <= '0;
            ptr     <= '0;
        end else if (xfer_in) begin
            out_val <= 1'b1;
            out_msg <= in_msg[grant_idx*p_nbits +: p_nbits];
            out_sel <= grant_idx;
            if (mode)
                ptr <= (grant_idx == p_sel_bits'(p_nchannels - 1)) ? '0 : grant_idx + 1'b1;
        end else if (out_val && out_rdy) begin
            out_val <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_rtl.sv
// Directed bench for mux_arb_rtl: an 8-channel and a 5-channel instance with queue scoreboards.
module tb_mux_arb_rtl;

    typedef struct packed {
        logic [31:0] msg;
        logic [3:0]  sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            mode8, out_rdy8, out_val8;
    logic [2:0]      sel8, out_sel8;
    logic [255:0]    in_msg8;
    logic [7:0]      in_val8, in_rdy8;
    logic [31:0]     out_msg8;

    logic            mode5, out_rdy5, out_val5;
    logic [2:0]      sel5, out_sel5;
    logic [159:0]    in_msg5;
    logic [4:0]      in_val5, in_rdy5;
    logic [31:0]     out_msg5;

    int checks   = 0;
    int failures = 0;
    exp_t q8[$];
    exp_t q5[$];

    mux_arb_rtl #(.p_nbits(32), .p_nchannels(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .mode(mode8), .sel(sel8),
        .in_msg(in_msg8), .in_val(in_val8), .in_rdy(in_rdy8),
        .out_msg(out_msg8), .out_val(out_val8), .out_sel(out_sel8), .out_rdy(out_rdy8)
    );

    mux_arb_rtl #(.p_nbits(32), .p_nchannels(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5),
        .in_msg(in_msg5), .in_val(in_val5), .in_rdy(in_rdy5),
        .out_msg(out_msg5), .out_val(out_val5), .out_sel(out_sel5), .out_rdy(out_rdy5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: every output transfer must match the oldest expected message.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_val8 === 1'b1 && out_rdy8 === 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb8_extra: unexpected output msg %0h sel %0d", out_msg8, out_sel8);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("sb8_msg", out_msg8, e.msg);
                chk("sb8_sel", {29'd0, out_sel8}, {28'd0, e.sel});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_val5 === 1'b1 && out_rdy5 === 1'b1) begin
            if (q5.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb5_extra: unexpected output msg %0h sel %0d", out_msg5, out_sel5);
            end else begin
                exp_t e;
                e = q5.pop_front();
                chk("sb5_msg", out_msg5, e.msg);
                chk("sb5_sel", {29'd0, out_sel5}, {28'd0, e.sel});
            end
        end
    end

    task automatic cyc8(input logic [7:0] er, input logic ev);
        exp_t e;
        @(negedge clk);
        chk("in_rdy8", {24'd0, in_rdy8}, {24'd0, er});
        chk("out_val8", {31'd0, out_val8}, {31'd0, ev});
        for (int i = 0; i < 8; i++) begin
            if (er[i]) begin
                e.msg = 32'hA0 + i;
                e.sel = 4'(i);
                q8.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc5(input logic [4:0] er, input logic ev);
        exp_t e;
        @(negedge clk);
        chk("in_rdy5", {27'd0, in_rdy5}, {27'd0, er});
        chk("out_val5", {31'd0, out_val5}, {31'd0, ev});
        for (int i = 0; i < 5; i++) begin
            if (er[i]) begin
                e.msg = 32'hA0 + i;
                e.sel = 4'(i);
                q5.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) in_msg8[i*32 +: 32] = 32'hA0 + i;
        for (int i = 0; i < 5; i++) in_msg5[i*32 +: 32] = 32'hA0 + i;
        rst_n = 1'b0;
        mode8 = 1'b1; sel8 = 3'd0; in_val8 = 8'hFF; out_rdy8 = 1'b1;
        mode5 = 1'b1; sel5 = 3'd0; in_val5 = 5'h1F; out_rdy5 = 1'b1;

        // Reset with all producers valid
        @(posedge clk);
        #1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_rdy8", {24'd0, in_rdy8}, 32'd0);
            chk("rst_out_val8", {31'd0, out_val8}, 32'd0);
            chk("rst_out_msg8", out_msg8, 32'd0);
            chk("rst_out_sel8", {29'd0, out_sel8}, 32'd0);
            chk("rst_in_rdy5", {27'd0, in_rdy5}, 32'd0);
            @(posedge clk);
            #1;
        end
        rst_n   = 1'b1;
        in_val5 = 5'h00;

        // Round-robin from reset pointer, then static sel=5 (ptr left at 3)
        cyc8(8'h01, 1'b0);
        cyc8(8'h02, 1'b1);
        cyc8(8'h04, 1'b1);
        mode8 = 1'b0; sel8 = 3'd5;
        repeat (4) cyc8(8'h20, 1'b1);

        // Round-robin resumes from ptr=3 over channels {0,2,7}
        mode8 = 1'b1; in_val8 = 8'b1000_0101;
        cyc8(8'h80, 1'b1);
        cyc8(8'h01, 1'b1);
        cyc8(8'h04, 1'b1);
        cyc8(8'h80, 1'b1);
        cyc8(8'h01, 1'b1);
        cyc8(8'h04, 1'b1);

        // Back-pressure: output holds channel 2, pointer stays at 3
        out_rdy8 = 1'b0;
        repeat (3) begin
            cyc8(8'h00, 1'b1);
            chk("bp_msg8", out_msg8, 32'hA2);
            chk("bp_sel8", {29'd0, out_sel8}, 32'd2);
        end
        out_rdy8 = 1'b1;
        cyc8(8'h80, 1'b1);
        cyc8(8'h01, 1'b1);

        // Reset while holding channel 3 with the consumer stalled
        mode8 = 1'b0; sel8 = 3'd3; in_val8 = 8'hFF;
        cyc8(8'h08, 1'b1);
        out_rdy8 = 1'b0;
        cyc8(8'h00, 1'b1);
        chk("hold_msg8", out_msg8, 32'hA3);
        rst_n = 1'b0;
        q8.delete();
        @(negedge clk);
        chk("midrst_in_rdy8", {24'd0, in_rdy8}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_out_val8", {31'd0, out_val8}, 32'd0);
        chk("midrst_out_msg8", out_msg8, 32'd0);
        chk("midrst_out_sel8", {29'd0, out_sel8}, 32'd0);
        mode8 = 1'b1; out_rdy8 = 1'b1;
        cyc8(8'h01, 1'b0);
        in_val8 = 8'h00;
        cyc8(8'h00, 1'b1);
        cyc8(8'h00, 1'b0);

        // Five channels: round-robin wrap over {0,4}
        mode5 = 1'b1; in_val5 = 5'b10001;
        cyc5(5'h01, 1'b0);
        cyc5(5'h10, 1'b1);
        cyc5(5'h01, 1'b1);
        cyc5(5'h10, 1'b1);

        // Out-of-range static select never grants; output drains
        mode5 = 1'b0; sel5 = 3'd6; in_val5 = 5'h1F;
        cyc5(5'h00, 1'b1);
        cyc5(5'h00, 1'b0);
        mode5 = 1'b1;
        cyc5(5'h01, 1'b0);
        cyc5(5'h02, 1'b1);
        in_val5 = 5'h00;
        cyc5(5'h00, 1'b1);
        cyc5(5'h00, 1'b0);

        repeat (2) @(posedge clk);
        chk("sb8_drained", q8.size(), 32'd0);
        chk("sb5_drained", q5.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
